// File: rtl/bpsk_demodulator.sv
// BPSK integrate-and-dump receiver: one hard decision per SPS offset-binary samples.
// Optional macro BPSK_DEMOD_SOFT_OUT_EN adds soft_out, the signed correlator sum.
module bpsk_demodulator #(
  parameter int unsigned SPS        = 16,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned LOWCONF_TH = 4096
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic [7:0]              wav_in,
  input  logic                    wav_valid,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    low_conf,
  output logic [$clog2(SPS)-1:0]  sym_phase
`ifdef BPSK_DEMOD_SOFT_OUT_EN
  ,
  output logic signed [ACC_W-1:0] soft_out
`endif
);

  localparam int unsigned PH_W = $clog2(SPS);
  localparam int unsigned STEP = 64 / SPS;

  typedef enum logic [1:0] {IDLE, INTEG, DUMP} state_t;

  // First quadrant of round(127*sin(2*pi*i/64)), i = 0..16.
  function automatic logic signed [7:0] quarter64(input int unsigned i);
    logic signed [7:0] v;
    case (i)
      0:       v = 8'sd0;
      1:       v = 8'sd12;
      2:       v = 8'sd25;
      3:       v = 8'sd37;
      4:       v = 8'sd49;
      5:       v = 8'sd60;
      6:       v = 8'sd71;
      7:       v = 8'sd81;
      8:       v = 8'sd90;
      9:       v = 8'sd98;
      10:      v = 8'sd106;
      11:      v = 8'sd112;
      12:      v = 8'sd117;
      13:      v = 8'sd122;
      14:      v = 8'sd125;
      15:      v = 8'sd126;
      16:      v = 8'sd127;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

  // Full 64-point sine by quadrant symmetry; smaller SPS tables subsample it exactly.
  function automatic logic signed [7:0] sine64(input int unsigned j);
    int unsigned q;
    int unsigned i;
    logic signed [7:0] v;
    q = (j / 16) % 4;
    i = j % 16;
    case (q)
      0:       v = quarter64(i);
      1:       v = quarter64(16 - i);
      2:       v = -quarter64(i);
      default: v = -quarter64(16 - i);
    endcase
    return v;
  endfunction

  logic signed [7:0] rom [SPS];

  for (genvar k = 0; k < SPS; k++) begin : g_rom
    assign rom[k] = sine64(k * STEP);
  end

  state_t                  state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic signed [ACC_W-1:0] final_sum, final_n;
  logic [PH_W-1:0]         phase_n;
  logic                    bit_n, valid_n, lc_n;

  logic signed [7:0]       smp;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] mag;

  // Offset-binary to two's complement, then correlate with the local carrier.
  assign smp      = {~wav_in[7], wav_in[6:0]};
  assign prod     = 16'(smp) * 16'(rom[sym_phase]);
  assign prod_ext = ACC_W'(prod);
  assign sum_c    = acc + prod_ext;
  assign mag      = final_sum[ACC_W-1] ? -final_sum : final_sum;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    phase_n = sym_phase;
    final_n = final_sum;
    bit_n   = bit_out;
    valid_n = 1'b0;
    lc_n    = low_conf;
    case (state)
      IDLE: begin
        if (wav_valid) begin
          acc_n   = prod_ext;
          phase_n = PH_W'(1);
          state_n = INTEG;
        end
      end
      INTEG: begin
        if (wav_valid) begin
          acc_n = sum_c;
          if (sym_phase == PH_W'(SPS - 1)) begin
            final_n = sum_c;
            phase_n = '0;
            state_n = DUMP;
          end else begin
            phase_n = sym_phase + PH_W'(1);
          end
        end
      end
      DUMP: begin
        // A zero sum decides 1; a sample arriving now starts the next symbol.
        bit_n   = ~final_sum[ACC_W-1];
        lc_n    = $unsigned(mag) < ACC_W'(LOWCONF_TH);
        valid_n = 1'b1;
        if (wav_valid) begin
          acc_n   = prod_ext;
          phase_n = PH_W'(1);
          state_n = INTEG;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      sym_phase <= '0;
      final_sum <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      low_conf  <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      sym_phase <= phase_n;
      final_sum <= final_n;
      bit_out   <= bit_n;
      bit_valid <= valid_n;
      low_conf  <= lc_n;
    end
  end

`ifdef BPSK_DEMOD_SOFT_OUT_EN
  // Soft value updates together with the hard decision.
  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      soft_out <= '0;
    end else if (state == DUMP) begin
      soft_out <= final_sum;
    end
  end
`endif

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: expected decisions are queued as symbols are
// driven and matched against each bit_valid strobe, including its cycle of arrival.
module tb_bpsk_demodulator;

  localparam int SPS        = 16;
  localparam int ACC_W      = 20;
  localparam int LOWCONF_TH = 4096;
  localparam real PI        = 3.14159265358979;

  typedef int sym_t [SPS];
  typedef struct {
    bit     b;
    bit     lc;
    longint sum;
    longint cyc;
  } exp_t;

  logic                    clk_fast = 1'b0;
  logic                    rst      = 1'b0;
  logic [7:0]              wav_in   = 8'd128;
  logic                    wav_valid = 1'b0;
  logic                    bit_out;
  logic                    bit_valid;
  logic                    low_conf;
  logic [3:0]              sym_phase;
`ifdef BPSK_DEMOD_SOFT_OUT_EN
  logic signed [ACC_W-1:0] soft_out;
`endif

  exp_t   sb[$];
  exp_t   mon_e;
  int     passes = 0;
  int     total  = 0;
  longint cyc    = 0;
  int     model_phase = 0;

  bpsk_demodulator #(.SPS(SPS), .ACC_W(ACC_W), .LOWCONF_TH(LOWCONF_TH)) dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .wav_in   (wav_in),
    .wav_valid(wav_valid),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .low_conf (low_conf),
    .sym_phase(sym_phase)
`ifdef BPSK_DEMOD_SOFT_OUT_EN
    ,
    .soft_out (soft_out)
`endif
  );

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) cyc <= cyc + 1;

  always @(posedge clk_fast or negedge rst) begin
    if (!rst) model_phase <= 0;
    else if (wav_valid) model_phase <= (model_phase + 1) % SPS;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ref_val(input int k);
    real r;
    r = 127.0 * $sin(2.0 * PI * k / SPS);
    return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic sym_t mk_bit(input bit b);
    sym_t w;
    for (int k = 0; k < SPS; k++) w[k] = b ? 128 + ref_val(k) : 128 - ref_val(k);
    return w;
  endfunction

  function automatic sym_t mk_flat();
    sym_t w;
    for (int k = 0; k < SPS; k++) w[k] = 128;
    return w;
  endfunction

  // Drives one symbol; stall_after < 0 means no stall.
  task automatic send_sym(input sym_t w, input int stall_after, input int stall_len);
    longint s = 0;
    exp_t   e;
    for (int k = 0; k < SPS; k++) begin
      wav_in    = 8'(w[k]);
      wav_valid = 1'b1;
      s += longint'(w[k] - 128) * longint'(ref_val(k));
      if (k == SPS - 1) begin
        e.b   = (s >= 0);
        e.lc  = (((s < 0) ? -s : s) < LOWCONF_TH);
        e.sum = s;
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
      @(posedge clk_fast); #1;
      if (k == stall_after) begin
        wav_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk_fast); #1;
        end
      end
    end
  endtask

  task automatic idle_drain(input string tag);
    wav_valid = 1'b0;
    wav_in    = 8'd128;
    for (int i = 0; i < 64 && sb.size() > 0; i++) begin
      @(posedge clk_fast); #1;
    end
    @(posedge clk_fast); #1;
    check(tag, longint'(sb.size()), 0);
  endtask

  // Compare every strobe against the scoreboard head; track phase every cycle.
  always @(negedge clk_fast) begin
    if (rst) begin
      check("sym_phase", longint'(sym_phase), longint'(model_phase));
      if (bit_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("bit_out", longint'(bit_out), longint'(mon_e.b));
          check("low_conf", longint'(low_conf), longint'(mon_e.lc));
          check("strobe_cycle", cyc, mon_e.cyc);
`ifdef BPSK_DEMOD_SOFT_OUT_EN
          check("soft_out", longint'(soft_out), mon_e.sum);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    sym_t w;

    repeat (3) @(posedge clk_fast);
    @(negedge clk_fast);
    check("rst_bit_out", longint'(bit_out), 0);
    check("rst_bit_valid", longint'(bit_valid), 0);
    check("rst_low_conf", longint'(low_conf), 0);
    check("rst_sym_phase", longint'(sym_phase), 0);
    @(posedge clk_fast); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk_fast); #1;

    send_sym(mk_bit(1'b1), -1, 0);
    idle_drain("drain_bit1");
    send_sym(mk_bit(1'b0), -1, 0);
    idle_drain("drain_bit0");

    send_sym(mk_bit(1'b1), -1, 0);
    send_sym(mk_bit(1'b0), -1, 0);
    send_sym(mk_bit(1'b0), -1, 0);
    send_sym(mk_bit(1'b1), -1, 0);
    send_sym(mk_bit(1'b1), -1, 0);
    idle_drain("drain_stream");

    send_sym(mk_bit(1'b1), 5, 7);
    idle_drain("drain_stall");

    send_sym(mk_flat(), -1, 0);
    idle_drain("drain_flat");

    // Sums at and just below the confidence threshold, and its negative.
    w = mk_flat(); w[3] = 201; w[4] = 93;
    send_sym(w, -1, 0);
    w[1] = 139; w[2] = 122;
    send_sym(w, -1, 0);
    w = mk_flat(); w[3] = 55; w[4] = 163;
    send_sym(w, -1, 0);
    idle_drain("drain_threshold");

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < SPS; k++) w[k] = 120 + int'($urandom_range(0, 16));
      send_sym(w, (n % 5 == 0) ? int'($urandom_range(0, SPS - 2)) : -1, 3);
    end
    idle_drain("drain_random");

    w = mk_bit(1'b1);
    for (int k = 0; k < 9; k++) begin
      wav_in    = 8'(w[k]);
      wav_valid = 1'b1;
      @(posedge clk_fast); #1;
    end
    wav_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk_fast);
    check("midrst_bit_out", longint'(bit_out), 0);
    check("midrst_bit_valid", longint'(bit_valid), 0);
    check("midrst_low_conf", longint'(low_conf), 0);
    check("midrst_sym_phase", longint'(sym_phase), 0);
    repeat (2) @(posedge clk_fast); #1;
    rst = 1'b1;
    @(posedge clk_fast); #1;
    send_sym(mk_bit(1'b0), -1, 0);
    idle_drain("drain_midrst");

    repeat (20) @(posedge clk_fast);
    #1;
    check("final_queue", longint'(sb.size()), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
